// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response bundle between the requester and alu_multicycle
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUop;
    logic             sz;
    logic             sgn;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic             branch;
    logic             div0;
    logic [WIDTH-1:0] result;

    modport master (
        output start, ALUop, sz, sgn, in1, in2,
        input  busy, done, branch, div0, result
    );

    modport slave (
        input  start, ALUop, sz, sgn, in1, in2,
        output busy, done, branch, div0, result
    );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle ops and iterative shift-add multiply / restoring divide
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic            clk,
    input logic            rst_n,
    alu_multicycle_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    logic [1:0]       state;
    logic             run_en;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc, opa, opb;
    logic [SHW-1:0]   cnt;
    logic             div0_pend;
    logic [WIDTH-1:0] result_q;
    logic             branch_q, div0_q;

    logic             accept, multi, lt, eq;
    logic [WIDTH-1:0] single_res;
    logic             single_br;
    logic [WIDTH-1:0] acc_nx, opb_nx;
    logic [WIDTH:0]   rem_sh, diff;

    // run_en rises one edge after reset release, so the release edge itself never accepts a start
    assign accept = run_en && (state == S_IDLE) && bus.start;
    assign multi  = !bus.sz && ((bus.ALUop == OP_MUL) || (bus.ALUop == OP_DIV));
    assign lt     = bus.sgn ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);
    assign eq     = (bus.in1 == bus.in2);

    always_comb begin
        single_res = '0;
        single_br  = 1'b0;
        if (bus.sz) begin
            single_res = bus.in2;
        end else begin
            case (bus.ALUop)
                4'd0:    single_res = bus.in1 + bus.in2;
                4'd1:    single_res = bus.in1 - bus.in2;
                4'd4:    single_res = bus.in1 & bus.in2;
                4'd5:    single_res = bus.in1 | bus.in2;
                4'd6:    single_res = ~bus.in1;
                4'd7:    single_br  = eq;
                4'd8:    single_br  = !lt;
                4'd9:    single_br  = lt || eq;
                4'd10:   single_br  = lt;
                4'd11:   single_br  = !(lt || eq);
                4'd12:   single_res = bus.in1 << bus.in2[SHW-1:0];
                4'd13:   single_res = bus.sgn ? $unsigned($signed(bus.in1) >>> bus.in2[SHW-1:0])
                                              : (bus.in1 >> bus.in2[SHW-1:0]);
                default: single_res = '0;
            endcase
        end
    end

    // One iteration: mult adds the shifted multiplicand; div shifts the next dividend bit into the remainder
    always_comb begin
        acc_nx = acc;
        opb_nx = opb >> 1;
        rem_sh = '0;
        diff   = '0;
        if (op_q == OP_MUL) begin
            if (opb[0]) acc_nx = acc + opa;
        end else begin
            rem_sh = {acc, opb[WIDTH-1]};
            diff   = rem_sh - {1'b0, opa};
            opb_nx = {opb[WIDTH-2:0], ~diff[WIDTH]};
            acc_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en    <= 1'b0;
            state     <= S_IDLE;
            op_q      <= '0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            cnt       <= '0;
            div0_pend <= 1'b0;
            result_q  <= '0;
            branch_q  <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            run_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (multi) begin
                            state     <= S_RUN;
                            op_q      <= bus.ALUop;
                            acc       <= '0;
                            opa       <= (bus.ALUop == OP_MUL) ? bus.in1 : bus.in2;
                            opb       <= (bus.ALUop == OP_MUL) ? bus.in2 : bus.in1;
                            cnt       <= '0;
                            div0_pend <= (bus.ALUop == OP_DIV) && (bus.in2 == '0);
                        end else begin
                            state    <= S_DONE;
                            result_q <= single_res;
                            branch_q <= single_br;
                            div0_q   <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nx;
                    opb <= opb_nx;
                    if (op_q == OP_MUL) opa <= opa << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state    <= S_DONE;
                        result_q <= (op_q == OP_MUL) ? acc_nx : opb_nx;
                        branch_q <= 1'b0;
                        div0_q   <= div0_pend;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.branch = branch_q;
    assign bus.div0   = div0_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with directed vectors
module tb_alu_multicycle;
    localparam int W = 32;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        br;
        logic        d0;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_multicycle_if #(.WIDTH(W)) bus();

    alu_multicycle #(.WIDTH(W), .SHW(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_res"}, 64'(bus.result), 64'(e.res));
                    chk({e.name, "_branch"}, 64'(bus.branch), 64'(e.br));
                    chk({e.name, "_div0"}, 64'(bus.div0), 64'(e.d0));
                    chk({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic s_z, input logic s_g,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eb, input logic ed, input int el);
        exp_t e;
        bit   idle = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle = 1;
                break;
            end
        end
        if (!idle) chk({nm, "_idle_timeout"}, 64'd1, 64'd0);
        bus.ALUop = op;
        bus.sz    = s_z;
        bus.sgn   = s_g;
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.name = nm; e.res = er; e.br = eb; e.d0 = ed; e.lat = el; e.acc = cyc;
        sb.push_back(e);
        bus.start = 1'b0;
        // scramble inputs so any failure to latch at acceptance shows up
        bus.ALUop = ~op;
        bus.sz    = ~s_z;
        bus.sgn   = ~s_g;
        bus.in1   = ~a;
        bus.in2   = b ^ 32'h5A5A_5A5A;
    endtask

    initial begin
        bit drained = 0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.ALUop = 4'd0;
        bus.sz    = 1'b0;
        bus.sgn   = 1'b0;
        bus.in1   = 32'd3;
        bus.in2   = 32'd4;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_edge_no_accept", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;

        issue("add_wrap", 4'd0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1);
        chk("single_busy_high", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        chk("single_busy_low", 64'(bus.busy), 64'd0);

        issue("sub_neg", 4'd1, 0, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1);
        issue("mult_1", 4'd2, 0, 0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 0, 0, 33);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.ALUop = 4'd0;
        bus.sz    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("run_start_ignored_busy", 64'(bus.busy), 64'd1);

        issue("div_100_7", 4'd3, 0, 0, 32'd100, 32'd7, 32'd14, 0, 0, 33);
        issue("div_by_0", 4'd3, 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1, 33);
        issue("blt_sgn", 4'd10, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1);
        repeat (4) @(negedge clk);
        chk("branch_hold", 64'(bus.branch), 64'd1);
        issue("blt_uns", 4'd10, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1);
        issue("shr_arith", 4'd13, 0, 1, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 1);
        issue("shr_logic", 4'd13, 0, 0, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0, 1);
        issue("sz_pass", 4'd3, 1, 0, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_1234, 0, 0, 1);
        issue("beq", 4'd7, 0, 0, 32'd5, 32'd5, 32'd0, 1, 0, 1);
        issue("bge_sgn", 4'd8, 0, 1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 1);
        issue("ble_uns", 4'd9, 0, 0, 32'd9, 32'd9, 32'd0, 1, 0, 1);
        issue("bgt_uns", 4'd11, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1);
        issue("and", 4'd4, 0, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 1);
        issue("or", 4'd5, 0, 0, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0, 0, 1);
        issue("not", 4'd6, 0, 0, 32'h0000_0000, 32'd7, 32'hFFFF_FFFF, 0, 0, 1);
        issue("shl", 4'd12, 0, 0, 32'd1, 32'd31, 32'h8000_0000, 0, 0, 1);
        issue("reserved", 4'd14, 0, 0, 32'd1, 32'd2, 32'd0, 0, 0, 1);
        issue("mult_max", 4'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0, 33);
        issue("div_big", 4'd3, 0, 0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0, 0, 33);

        issue("div_abort", 4'd3, 0, 0, 32'd100, 32'd7, 32'd14, 0, 0, 33);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_flags", 64'({bus.branch, bus.div0}), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", 64'(bus.busy), 64'd0);
        issue("sub_after_reset", 4'd1, 0, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                drained = 1;
                break;
            end
        end
        chk("drain", 64'(drained), 64'd1);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=4).
REQ-002 SHALL have parameter SHW, default 5, shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  operation request, sampled on clk rising edge.
REQ-006 SHALL have port ALUop  input  4  operation code (REQ-012).
REQ-007 SHALL have port sz  input  1  address pass-through: result = in2, ALUop ignored.
REQ-008 SHALL have port sgn  input  1  1 = two's-complement compares/right shift; 0 = unsigned.
REQ-009 SHALL have ports in1, in2  input  WIDTH each  operands.
REQ-010 SHALL have ports busy  output 1; done  output 1 (one-cycle pulse); branch  output 1; div0  output 1; result  output WIDTH.
REQ-011 One clock and one reset only: clk, and rst_n asynchronous active-low.

Function
REQ-012 ALUop: 0000 add, 0001 sub, 0010 mult, 0011 div, 0100 and, 0101 or, 0110 not(in1), 0111 beq, 1000 bge, 1001 ble, 1010 blt, 1011 bgt, 1100 shl, 1101 shr, 1110/1111 reserved.
REQ-013 FSM states IDLE, RUN, DONE; start accepted only in IDLE; start while busy SHALL be ignored, operands not re-latched.
REQ-014 On acceptance: in1, in2, ALUop, sz, sgn latched; later input changes SHALL not affect the operation.
REQ-015 Single-cycle ops (all except mult/div, plus any op with sz=1): IDLE -> DONE; done=1 in cycle after acceptance edge (latency 1).
REQ-016 mult/div (sz=0): IDLE -> RUN for exactly WIDTH cycles -> DONE; done=1 WIDTH+1 cycles after acceptance edge.
REQ-017 DONE lasts one cycle then -> IDLE; back-to-back start SHALL be accepted in the DONE->IDLE cycle's following edge (start sampled in IDLE only).
REQ-018 busy=1 in RUN and DONE, 0 in IDLE.
REQ-019 add/sub/mult: result modulo 2**WIDTH; mult = low WIDTH bits of unsigned product, iterative shift-add, one bit per cycle.
REQ-020 div: unsigned restoring, one quotient bit per cycle; result = quotient.
REQ-021 div with in2=0: result = all ones, div0=1 with done; div0=0 for every other completion.
REQ-022 Compares (0111-1011): branch = comparison result per sgn, result = 0; all other ops branch = 0.
REQ-023 shl/shr: shift in1 by in2[SHW-1:0]; shr arithmetic when sgn=1, logical when sgn=0.
REQ-024 Reserved ALUop: result=0, branch=0, latency 1.
REQ-025 result, branch, div0 update only at done and SHALL hold until next done.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, branch=0, div0=0, result=0, clearing internal accumulators.
REQ-027 Reset during RUN SHALL abort the operation without any done pulse; first start after release behaves normally.
REQ-028 Deassertion SHALL be synchronised so no start is accepted on the deassertion edge.

Verification (WIDTH=32)
REQ-029 add 0xFFFFFFFF + 1, start 1 cycle -> done next cycle, result=0, branch=0, busy high one cycle.
REQ-030 mult 0x00010001 * 0x00010001 -> done exactly 33 cycles after acceptance, result=0x00020001; start pulses during RUN ignored.
REQ-031 div 100/7 -> result=14, div0=0; then div 5/0 -> result=0xFFFFFFFF, div0=1.
REQ-032 blt in1=0xFFFFFFFF, in2=1: sgn=1 -> branch=1; sgn=0 -> branch=0; shr 0x80000000 by 4 sgn=1 -> 0xF8000000.
REQ-033 sz=1, ALUop=div, in2=0x1234 -> latency 1, result=0x1234, div0=0.
REQ-034 reset asserted 10 cycles into div -> outputs 0 immediately, no done; subsequent sub 5-7 -> result=0xFFFFFFFE.
